// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_mult_pkg;

   // Operand width the existing adder supports
   localparam int DEF_WIDTH = 4;

   // Iteration counter width
   localparam int CNT_W = $clog2(DEF_WIDTH);

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/part2.sv
// Existing 4-bit ripple-carry adder used as the multiplier's add stage.
module part2 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] S,
   output logic       Cout
);

   logic [4:0] w_c;

   assign w_c[0] = Cin;

   // One full adder per bit, carry rippling upward
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign S[i]     = A[i] ^ B[i] ^ w_c[i];
      assign w_c[i+1] = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
   end

   assign Cout = w_c[4];

endmodule

// File: rtl/seq_mult4.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one add-and-shift step per
// cycle through the shared ripple-carry adder, valid/ready on both sides.
module seq_mult4
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]   mplr_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_acc_hi;
   logic [WIDTH-1:0]   r_acc_lo;
   logic [CNT_W-1:0]   r_count;
   logic [2*WIDTH-1:0] r_product;

   logic [WIDTH-1:0]   w_add_b;
   logic [WIDTH-1:0]   w_sum;
   logic               w_cout;
   logic [2*WIDTH-1:0] w_shifted;
   logic               w_accept;
   logic               w_last;

   // Partial-product term: add the multiplicand only when the current LSB is set
   assign w_add_b = r_acc_lo[0] ? r_mcand : '0;

   part2 u_add (
      .A    (r_acc_hi),
      .B    (w_add_b),
      .Cin  (1'b0),
      .S    (w_sum),
      .Cout (w_cout)
   );

   // {Cout,S,acc_lo} shifted right by one; the carry becomes the new MSB
   assign w_shifted = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
   assign w_accept  = start & in_ready;
   assign w_last    = (r_count == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic and state-decoded handshake outputs
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (start) w_next_state = S_CALC;
         end
         S_CALC: begin
            if (w_last) w_next_state = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Operand load, iterative accumulate/shift and result capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mcand   <= '0;
         r_acc_hi  <= '0;
         r_acc_lo  <= '0;
         r_count   <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mcand  <= mcand_in;
                  r_acc_lo <= mplr_in;
                  r_acc_hi <= '0;
                  r_count  <= '0;
               end
            end
            S_CALC: begin
               {r_acc_hi, r_acc_lo} <= w_shifted;
               // Counter wraps back to zero on the final step
               r_count <= r_count + CNT_W'(1);
               // Product is held in its own register so it survives the next load
               if (w_last) r_product <= w_shifted;
            end
            default: ;
         endcase
      end
   end

   assign product = r_product;

endmodule

// File: tb/tb_seq_mult4.sv
// Self-checking bench for seq_mult4.
module tb_seq_mult4;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       in_ready;
   logic [3:0] mcand_in;
   logic [3:0] mplr_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] product;

   int tests = 0;
   int fails = 0;

   seq_mult4 dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_ready  (in_ready),
      .mcand_in  (mcand_in),
      .mplr_in   (mplr_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a job is busy from acceptance until handshake; the
   // result is offered after 4 edges and equals the plain product.
   bit       chk_en = 0;
   bit       m_busy = 0;
   int       m_age  = 0;
   int       m_exp  = 0;
   int       n_results = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 0;
         m_age  = 0;
         chk_en = 1;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1;
            m_age  = 0;
            m_exp  = int'(mcand_in) * int'(mplr_in);
         end
      end else if (m_age < 4) begin
         m_age++;
      end else if (out_ready) begin
         m_busy = 0;
         n_results++;
      end
   end

   // Compare process: handshake outputs every cycle, product while offered
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", 16'(in_ready), 16'(!m_busy));
         check("out_valid", 16'(out_valid), 16'(m_busy && m_age == 4));
         if (m_busy && m_age == 4) check("product", 16'(product), 16'(m_exp));
      end
   end

   // Issue one multiplication from IDLE and wait for its result
   task automatic do_mult(input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] p, output int lat);
      bit ok;
      @(negedge clk);
      mcand_in = a;
      mplr_in  = b;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok  = 0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin
            ok  = 1;
            lat = i;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("result_timeout", 16'(0), 16'(1));
      p = product;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (in_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("idle_timeout", 16'(0), 16'(1));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] p;
   int         lat;
   int         nres;
   logic [3:0] sa [4] = '{4'd9, 4'd0, 4'd13, 4'd1};
   logic [3:0] sb [4] = '{4'd6, 4'd13, 4'd0, 4'd15};
   logic [7:0] sp [4] = '{8'h36, 8'h00, 8'h00, 8'h0F};

   initial begin
      reset     = 1'b1;
      start     = 1'($urandom);
      mcand_in  = 4'($urandom);
      mplr_in   = 4'($urandom);
      out_ready = 1'($urandom);
      repeat (2) begin
         @(negedge clk);
         start    = 1'($urandom);
         mcand_in = 4'($urandom);
         mplr_in  = 4'($urandom);
      end
      check("rst_in_ready", 16'(in_ready), 16'(1));
      check("rst_out_valid", 16'(out_valid), 16'(0));
      check("rst_product", 16'(product), 16'h00);
      reset     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;

      // 15*15: carry-out path and exact latency
      do_mult(4'hF, 4'hF, p, lat);
      check("p15x15", 16'(p), 16'h00E1);
      check("lat15x15", 16'(lat), 16'(4));
      @(negedge clk);
      check("idle_after_hs", 16'(in_ready), 16'(1));

      // Spot values
      for (int i = 0; i < 4; i++) begin
         wait_idle();
         do_mult(sa[i], sb[i], p, lat);
         check("spot", 16'(p), 16'(sp[i]));
      end

      // Backpressure on 7*5
      wait_idle();
      out_ready = 1'b0;
      do_mult(4'd7, 4'd5, p, lat);
      check("p7x5", 16'(p), 16'h0023);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", 16'(out_valid), 16'(1));
         check("bp_product", 16'(product), 16'h0023);
         check("bp_in_ready", 16'(in_ready), 16'(0));
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_idle", 16'(in_ready), 16'(1));
      check("bp_release_valid", 16'(out_valid), 16'(0));

      // Start pulse during CALC must be ignored
      wait_idle();
      nres = n_results;
      @(negedge clk);
      mcand_in = 4'd3;
      mplr_in  = 4'd4;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      mcand_in = 4'hF;
      mplr_in  = 4'hF;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         bit ok = 0;
         for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
               ok = 1;
               break;
            end
            @(negedge clk);
         end
         if (!ok) check("busy_timeout", 16'(0), 16'(1));
      end
      check("p3x4_busy", 16'(product), 16'h000C);
      repeat (10) @(negedge clk);
      check("busy_one_result", 16'(n_results - nres), 16'(1));
      check("busy_no_valid", 16'(out_valid), 16'(0));

      // Reset on the second CALC edge aborts 11*11
      wait_idle();
      nres = n_results;
      @(negedge clk);
      mcand_in = 4'd11;
      mplr_in  = 4'd11;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_in_ready", 16'(in_ready), 16'(1));
      check("abort_out_valid", 16'(out_valid), 16'(0));
      check("abort_product", 16'(product), 16'h00);
      repeat (8) begin
         @(negedge clk);
         check("abort_never_valid", 16'(out_valid), 16'(0));
      end
      check("abort_no_result", 16'(n_results - nres), 16'(0));
      do_mult(4'd2, 4'd3, p, lat);
      check("p2x3", 16'(p), 16'h0006);

      // Exhaustive sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            wait_idle();
            do_mult(4'(a), 4'(b), p, lat);
            check("sweep", 16'(p), 16'(a * b));
         end
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_mult4.md
Name: seq_mult4

Overview:
- Sequential unsigned shift-and-add multiplier that computes a WIDTH x WIDTH product in WIDTH iterations.
- Sits directly downstream of the 4-bit ripple-carry adder: it owns the operand registers and feeds the adder its A/B/Cin each cycle.
- It then consumes the adder's S/Cout to build the 2*WIDTH-bit product.
- Uses a valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 4, operand width. Only 4 is supported with the existing 4-bit adder; other values require an equal-width adder.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all state on a rising clk edge while high
- start  input  1  request to begin a multiplication with mcand_in/mplr_in
- in_ready  output  1  block idle and able to accept start
- mcand_in  input  WIDTH  multiplicand, sampled only on the accepting edge
- mplr_in  input  WIDTH  multiplier, sampled only on the accepting edge
- out_valid  output  1  product is valid and held stable
- out_ready  input  1  consumer accepts the product
- product  output  2*WIDTH  unsigned result

Behaviour:
- Reset (synchronous): state=IDLE, in_ready=1, out_valid=0, product=0, internal acc_hi/acc_lo/mcand/count=0. Reset wins over every other input on the same edge. Reset mid-CALC or mid-DONE aborts the operation with no output.
- States: IDLE, CALC, DONE. Encoding is free; outputs are decoded from state.
- IDLE:
  - in_ready=1, out_valid=0.
  - Acceptance edge = start & in_ready. On it: mcand<=mcand_in, acc_lo<=mplr_in, acc_hi<=0, count<=0, state<=CALC.
  - start=0: stay in IDLE, registers unchanged.
- CALC:
  - in_ready=0, out_valid=0. start is ignored and operands are not resampled.
  - Adder inputs are A=acc_hi, B=(acc_lo[0] ? mcand : 0), Cin=0.
  - Each edge: {acc_hi,acc_lo} <= {Cout,S,acc_lo} >> 1, taking a (2*WIDTH+1)-bit value and keeping the low 2*WIDTH bits. count<=count+1.
  - When count==WIDTH-1 on an edge, state<=DONE.
- Latency: exactly WIDTH CALC edges. For WIDTH=4, out_valid rises after the 4th edge following the acceptance edge.
- DONE:
  - out_valid=1, in_ready=0, product={acc_hi,acc_lo}, stable until handshake.
  - out_ready=1 on an edge: state<=IDLE. out_valid drops the next cycle, and the product register keeps its last value.
  - out_ready=0: hold indefinitely. This is the backpressure case.
  - out_ready high before DONE has no effect.
- Back-to-back:
  - A new start is accepted only in IDLE, so the minimum issue interval is WIDTH+2 cycles.
  - start held high continuously is accepted on the first IDLE cycle after each handshake.
- Arithmetic:
  - Unsigned only. Result range 0..(2^WIDTH-1)^2, so no overflow is possible in 2*WIDTH bits.
  - The adder carry-out must be captured into the shifted value every step.
- count is log2(WIDTH) bits wide. It wraps to 0 when returning to IDLE and is reloaded on acceptance.

Decomposition:
- Shared package (seq_mult_pkg):
  - State enum localparams S_IDLE/S_CALC/S_DONE.
  - Default WIDTH=4.
  - CNT_W = $clog2(WIDTH).
- One sub-module: the existing 4-bit ripple-carry adder (part2), instantiated once as the add stage. It is not duplicated or modified.
- FSM, counter and shift registers stay in seq_mult4.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> in_ready=1, out_valid=0, product=0x00.
- 15*15: start with mcand=0xF, mplr=0xF, out_ready=1 -> out_valid after exactly 4 CALC edges, product=0xE1 (225). Exercises the carry-out path.
- Spot values: 9*6 -> 0x36; 0*13 -> 0x00; 13*0 -> 0x00; 1*15 -> 0x0F. Exhaustive 256-pair sweep against a reference model -> zero mismatches.
- Backpressure: complete 7*5 with out_ready=0 for 10 cycles -> out_valid stays 1, product stays 0x23, in_ready stays 0. Raise out_ready -> IDLE next cycle.
- Start while busy: accept 3*4, pulse start with 0xF/0xF during CALC -> ignored, product=0x0C, no second result.
- Reset mid-operation: accept 11*11, assert reset on the 2nd CALC edge -> IDLE, out_valid never rises. Next 2*3 -> product=0x06.
